// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the cache line burst logic.
//   state_t      : burst adapter FSM states (IDLE, WRITE, READ, DONE)
//   line_bits()  : word-counter width for a line of the given word count
//   offset_bits(): byte-offset width of a line (low address bits cleared
//                  to form the line base)
//   LINE_BITS / OFFSET_BITS : the above evaluated for the default geometry
//                  (8 words of 32 bits)
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEF_WORD_W     = 32;
   localparam int DEF_LINE_WORDS = 8;

   function automatic int line_bits(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int offset_bits(input int line_words, input int word_w);
      return $clog2(line_words * word_w / 8);
   endfunction

   localparam int LINE_BITS   = line_bits(DEF_LINE_WORDS);
   localparam int OFFSET_BITS = offset_bits(DEF_LINE_WORDS, DEF_WORD_W);

endpackage

// File: rtl/line_burst_adapter.sv
// line_burst_adapter
// Moves one cache line between a line-wide client port and a word-wide
// memory port. A write-back (optionally followed by a fill) or a fill alone
// is accepted only while idle; each memory word is presented until the
// memory acknowledges it with mem_valid.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   rd_req, rd_addr     line fill request and byte address
//   wr_req, wr_addr     line write-back request and byte address
//   wr_line             line data to write back (word i at [i*WORD_W +: WORD_W])
//   rd_line             filled line, held until the next fill stores a word
//   busy                high while words are being transferred
//   done                one-cycle completion pulse
//   mem_addr            byte address of the current word
//   mem_re, mem_we      word read / write strobes
//   mem_wdata           word being written
//   mem_rdata           word being read
//   mem_valid           memory accepts/returns the current word
//   dbg_state           current FSM state
//
// Handshake: a word transfer completes on a rising edge where the strobe
// (mem_re or mem_we) is high and mem_valid is high; until then address,
// strobe and write data stay constant. mem_valid without a strobe is ignored.
module line_burst_adapter
   import cache_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 32
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         rd_req,
   input  logic                         wr_req,
   input  logic [ADDR_W-1:0]            rd_addr,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [WORD_W*LINE_WORDS-1:0] wr_line,
   output logic [WORD_W*LINE_WORDS-1:0] rd_line,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic                         mem_re,
   output logic                         mem_we,
   output logic [WORD_W-1:0]            mem_wdata,
   input  logic [WORD_W-1:0]            mem_rdata,
   input  logic                         mem_valid,
   output state_t                       dbg_state
);

   localparam int CNT_W  = line_bits(LINE_WORDS);
   localparam int OFF_W  = offset_bits(LINE_WORDS, WORD_W);
   localparam int LINE_W = WORD_W * LINE_WORDS;

   localparam logic [ADDR_W-1:0] BASE_MASK  = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WORD_W / 8);
   localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(LINE_WORDS - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_fill_pend;
   logic [ADDR_W-1:0]   r_wr_base;
   logic [ADDR_W-1:0]   r_rd_base;
   logic [LINE_W-1:0]   r_wr_line;
   logic [LINE_W-1:0]   r_rd_line;
   logic                w_last;
   logic [ADDR_W-1:0]   w_word_off;

   assign w_last     = (r_cnt == LAST_CNT);
   // Address arithmetic wraps naturally at ADDR_W bits.
   assign w_word_off = ADDR_W'(r_cnt) * WORD_BYTES;
   assign rd_line    = r_rd_line;
   assign dbg_state  = r_state;

   // FSM state and word counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state and outputs
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      busy        = 1'b0;
      done        = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            // Write-back has precedence; a simultaneous fill is queued behind it.
            if (wr_req) begin
               w_state_nxt = ST_WRITE;
            end else if (rd_req) begin
               w_state_nxt = ST_READ;
            end
         end
         ST_WRITE: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_wr_base + w_word_off;
            mem_wdata = r_wr_line[int'(r_cnt)*WORD_W +: WORD_W];
            if (mem_valid) begin
               if (w_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = r_fill_pend ? ST_READ : ST_DONE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         ST_READ: begin
            busy     = 1'b1;
            mem_re   = 1'b1;
            mem_addr = r_rd_base + w_word_off;
            if (mem_valid) begin
               if (w_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Request capture and read-data storage
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_fill_pend <= 1'b0;
         r_wr_base   <= '0;
         r_rd_base   <= '0;
         r_wr_line   <= '0;
         r_rd_line   <= '0;
      end else begin
         if (r_state == ST_IDLE) begin
            if (wr_req) begin
               r_wr_line   <= wr_line;
               r_wr_base   <= wr_addr & BASE_MASK;
               r_rd_base   <= rd_addr & BASE_MASK;
               r_fill_pend <= rd_req;
            end else if (rd_req) begin
               r_rd_base   <= rd_addr & BASE_MASK;
               r_fill_pend <= 1'b0;
            end
         end
         if ((r_state == ST_READ) && mem_valid) begin
            r_rd_line[int'(r_cnt)*WORD_W +: WORD_W] <= mem_rdata;
         end
         if (r_state == ST_DONE) begin
            r_fill_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_line_burst_adapter.sv
`timescale 1ns/1ps
module tb_line_burst_adapter;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- default-geometry DUT ----------------
  logic         rd_req = 1'b0;
  logic         wr_req = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic [31:0]  wr_addr = '0;
  logic [255:0] wr_line = '0;
  logic [255:0] rd_line;
  logic         busy, done, mem_re, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_valid = 1'b0;
  state_t       dbg_state;
  logic [7:0]   rd_pat = 8'hA0;

  // memory returns rd_pat + word index within its line
  function automatic logic [31:0] mem_fn(input logic [31:0] addr, input logic [7:0] pat);
    return {24'h0, pat} + ((addr >> 2) & 32'h7);
  endfunction

  assign mem_rdata = mem_fn(mem_addr, rd_pat);

  line_burst_adapter u_dut (
    .CLK(clk), .RST(rst),
    .rd_req(rd_req), .wr_req(wr_req), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_line(wr_line), .rd_line(rd_line), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .dbg_state(dbg_state)
  );

  // ---------------- 4 x 64-bit DUT ----------------
  logic         b_rd_req = 1'b0;
  logic [31:0]  b_rd_addr = '0;
  logic [255:0] b_rd_line;
  logic         b_busy, b_done, b_mem_re, b_mem_we;
  logic [31:0]  b_mem_addr;
  logic [63:0]  b_mem_wdata, b_mem_rdata;
  state_t       b_dbg_state;

  assign b_mem_rdata = {32'h0, b_mem_addr};

  line_burst_adapter #(.WORD_W(64), .LINE_WORDS(4), .ADDR_W(32)) u_dut4 (
    .CLK(clk), .RST(rst),
    .rd_req(b_rd_req), .wr_req(1'b0), .rd_addr(b_rd_addr), .wr_addr(32'h0),
    .wr_line(256'h0), .rd_line(b_rd_line), .busy(b_busy), .done(b_done),
    .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_valid(1'b1), .dbg_state(b_dbg_state)
  );

  // ---------------- mem_valid driver ----------------
  int vmode = 0; // 0: always 1, 1: toggles every cycle
  always @(posedge clk) begin
    #2;
    if (vmode == 0) mem_valid = 1'b1;
    else            mem_valid = ~mem_valid;
  end

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  beat_t        exp_q[$];
  logic [255:0] exp_fill_line = '0;
  logic [255:0] model_rd_line = '0;
  bit           fill_in_q = 1'b0;
  bit           done_due = 1'b0;
  bit           chk_en = 1'b0;
  int           done_cnt = 0;
  int           done_cyc = 0;

  task automatic model_push(input bit rd, input bit wr, input logic [31:0] ra,
                            input logic [31:0] wa, input logic [255:0] wl);
    logic [31:0] base;
    beat_t b;
    if (wr) begin
      base = wa & 32'hFFFF_FFE0;
      for (int i = 0; i < 8; i++) begin
        b.addr = base + 32'(i * 4);
        b.we   = 1'b1;
        b.data = wl[i*32 +: 32];
        exp_q.push_back(b);
      end
    end
    fill_in_q = rd;
    if (rd) begin
      base = ra & 32'hFFFF_FFE0;
      for (int i = 0; i < 8; i++) begin
        b.addr = base + 32'(i * 4);
        b.we   = 1'b0;
        b.data = mem_fn(b.addr, rd_pat);
        exp_fill_line[i*32 +: 32] = b.data;
        exp_q.push_back(b);
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (exp_q.size() > 0) begin
        chkb("busy_xfer", busy, 1'b1);
        chkb("done_xfer", done, 1'b0);
        chkb("mem_we", mem_we, exp_q[0].we);
        chkb("mem_re", mem_re, !exp_q[0].we);
        chk32("mem_addr", mem_addr, exp_q[0].addr);
        if (exp_q[0].we) chk32("mem_wdata", mem_wdata, exp_q[0].data);
        if (mem_valid) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end else if (done_due) begin
        chkb("done_pulse", done, 1'b1);
        chkb("busy_done", busy, 1'b0);
        chkb("re_done", mem_re, 1'b0);
        chkb("we_done", mem_we, 1'b0);
        if (fill_in_q) model_rd_line = exp_fill_line;
        chkw("rd_line_done", rd_line, model_rd_line);
        done_due = 1'b0;
        done_cnt++;
        done_cyc = cyc;
      end else begin
        chkb("busy_idle", busy, 1'b0);
        chkb("done_idle", done, 1'b0);
        chkb("re_idle", mem_re, 1'b0);
        chkb("we_idle", mem_we, 1'b0);
        chkw("rd_line_hold", rd_line, model_rd_line);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit rd, input bit wr, input logic [31:0] ra,
                       input logic [31:0] wa, input logic [255:0] wl, output int start);
    @(posedge clk); #2;
    rd_req = rd; wr_req = wr; rd_addr = ra; wr_addr = wa; wr_line = wl;
    start = cyc;
    @(posedge clk); #2;
    rd_req = 1'b0; wr_req = 1'b0;
    model_push(rd, wr, ra, wa, wl);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() > 0 || done_due) && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL timeout: got %0d beats left expected 0 (cycle %0d)", exp_q.size(), cyc);
      exp_q.delete();
      done_due = 1'b0;
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [7:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {24'h0, base + 8'(i)};
    return l;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int d0;
    logic [31:0] baddr[8];
    int bn;
    int bdone;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_re", mem_re, 1'b0);
    chkb("rst_we", mem_we, 1'b0);
    chk32("rst_addr", mem_addr, 32'h0);
    chk32("rst_wdata", mem_wdata, 32'h0);
    chkw("rst_rd_line", rd_line, 256'h0);
    chk32("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chkb("rst_b_busy", b_busy, 1'b0);
    chkw("rst_b_rd_line", b_rd_line, 256'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // fill, mem_valid tied high
    vmode = 0; rd_pat = 8'hA0;
    issue(1'b1, 1'b0, 32'h1004, 32'h0, 256'h0, st);
    wait_done();
    chk32("fill_done_cycle", 32'(done_cyc - st), 32'd9);
    chkw("fill_line_literal", rd_line,
         256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);

    // write-back with mem_valid every other cycle
    vmode = 1;
    d0 = done_cnt;
    issue(1'b0, 1'b1, 32'h0, 32'h2000, mk_line(8'hB0), st);
    wait_done();
    repeat (4) @(posedge clk);
    chk32("wb_done_once", 32'(done_cnt - d0), 32'd1);

    // write-back then fill from one request
    vmode = 0; rd_pat = 8'hC0;
    issue(1'b1, 1'b1, 32'h4000, 32'h3000, mk_line(8'hD0), st);
    wait_done();
    chk32("combo_done_cycle", 32'(done_cyc - st), 32'd17);
    chkw("combo_line_literal", rd_line,
         256'h000000C7_000000C6_000000C5_000000C4_000000C3_000000C2_000000C1_000000C0);

    // requests while busy and mem_valid while idle are ignored
    vmode = 0; rd_pat = 8'h50;
    d0 = done_cnt;
    issue(1'b1, 1'b0, 32'h5010, 32'h0, 256'h0, st);
    @(posedge clk); #2;
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'h9000; wr_addr = 32'h9800;
    @(posedge clk); #2;
    rd_req = 1'b0; wr_req = 1'b0;
    wait_done();
    vmode = 1;
    repeat (8) @(posedge clk);
    chk32("ignored_req_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk32("ignored_state", 32'(dbg_state), 32'(ST_IDLE));

    // reset after the third read word
    vmode = 0; rd_pat = 8'hE0;
    d0 = done_cnt;
    issue(1'b1, 1'b0, 32'h6000, 32'h0, 256'h0, st);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    done_due = 1'b0;
    model_rd_line = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk32("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    chkw("abort_rd_line", rd_line, 256'h0);
    chkb("abort_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    chk32("abort_no_done", 32'(done_cnt - d0), 32'd0);
    rd_pat = 8'h10;
    issue(1'b1, 1'b0, 32'h7000, 32'h0, 256'h0, st);
    wait_done();
    chk32("refill_done_cycle", 32'(done_cyc - st), 32'd9);
    chkw("refill_line_literal", rd_line,
         256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010);

    // 4 x 64-bit geometry, line at top of address space
    @(posedge clk); #2;
    b_rd_req = 1'b1; b_rd_addr = 32'hFFFF_FFE8;
    st = cyc;
    @(posedge clk); #2;
    b_rd_req = 1'b0;
    bn = 0; bdone = -1;
    for (int k = 0; k < 20 && bdone < 0; k++) begin
      @(negedge clk);
      if (b_mem_re && bn < 8) begin
        baddr[bn] = b_mem_addr;
        bn++;
      end
      if (b_done) bdone = cyc;
    end
    chk32("w64_beats", 32'(bn), 32'd4);
    chk32("w64_addr0", baddr[0], 32'hFFFF_FFE0);
    chk32("w64_addr1", baddr[1], 32'hFFFF_FFE8);
    chk32("w64_addr2", baddr[2], 32'hFFFF_FFF0);
    chk32("w64_addr3", baddr[3], 32'hFFFF_FFF8);
    chk32("w64_done_cycle", 32'(bdone - st), 32'd5);
    chkw("w64_line", b_rd_line,
         256'h00000000FFFFFFF8_00000000FFFFFFF0_00000000FFFFFFE8_00000000FFFFFFE0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
